// File: rtl/fixed_quant_pkg.sv
// Shared definitions for the int8 absmax quantizer and the dequantizing linear
// layer downstream of it.
//   Q_MAX / Q_WIDTH : symmetric int8 code range (codes live in [-Q_MAX, Q_MAX])
//   quant_state_t   : quantizer control states
//   recip_width()   : width of the reciprocal scale 127 << frac
//   round_bias()    : half-LSB constant added before an arithmetic right shift
package fixed_quant_pkg;

    localparam int Q_MAX   = 127;
    localparam int Q_WIDTH = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DIV   = 2'd1,
        DRAIN = 2'd2
    } quant_state_t;

    // 127 needs 7 bits, so 127 << frac needs 7 + frac bits.
    function automatic int recip_width(input int frac);
        return 7 + frac;
    endfunction

    // Adding half an output LSB before a floor shift rounds half toward +inf.
    function automatic longint round_bias(input int frac);
        return (frac > 0) ? (longint'(1) << (frac - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/fixed_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load dividend/divisor and begin (ignored semantics of busy: restarts)
//   dividend  : DIVIDEND_WIDTH-bit unsigned numerator
//   divisor   : DIVISOR_WIDTH-bit unsigned denominator
//   busy      : high while quotient bits are being produced
//   done      : one-cycle pulse once the quotient is complete
//   quotient  : floor(dividend / divisor); 0 when divisor is 0
// The divide takes DIVIDEND_WIDTH cycles after start; done is high in the
// cycle following the last quotient bit.
module fixed_serial_divider #(
    parameter int DIVIDEND_WIDTH = 23,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    logic [CNT_W-1:0]          cnt;
    logic [DIVISOR_WIDTH-1:0]  rem;
    logic [DIVISOR_WIDTH-1:0]  dvsr;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_WIDTH-1:0] work;

    logic [DIVISOR_WIDTH:0]    rem_sh;
    logic [DIVISOR_WIDTH:0]    rem_sub;
    logic                      fits;

    always_comb begin
        rem_sh  = {rem, work[DIVIDEND_WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvsr};
        fits    = (rem_sh >= {1'b0, dvsr});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvsr <= '0;
            work <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                rem  <= '0;
                dvsr <= divisor;
                work <= dividend;
            end else if (busy) begin
                // The partial remainder stays below the divisor, so it fits
                // back into DIVISOR_WIDTH bits either way.
                rem  <= fits ? rem_sub[DIVISOR_WIDTH-1:0] : rem_sh[DIVISOR_WIDTH-1:0];
                work <= {work[DIVIDEND_WIDTH-2:0], fits};
                cnt  <= cnt + 1'b1;
                if (cnt == CNT_W'(DIVIDEND_WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // A zero divisor makes every trial subtraction "fit"; mask that to 0.
    assign quotient = (dvsr == '0) ? '0 : work;

endmodule

// File: rtl/fixed_absmax_quantizer.sv
// Streaming per-vector absmax quantizer (int8 activation path).
// Buffers IN_DEPTH beats of IN_PARALLELISM signed elements, finds the vector
// absmax, computes R = floor((127 << RECIP_FRAC) / absmax) serially, then
// emits q = sat(round(x * R >> RECIP_FRAC)) per element with the absmax.
//   clk, rst               : clock, asynchronous active-low reset
//   data_in[]              : signed input elements, one beat
//   data_in_valid/ready    : input handshake (ready only while filling)
//   data_out[]             : signed int8 codes in [-127, 127]
//   data_out_max_num       : absmax of the vector being emitted
//   data_out_valid/ready   : output handshake
module fixed_absmax_quantizer
    import fixed_quant_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int IN_PARALLELISM = 4,
    parameter int IN_DEPTH       = 2,
    parameter int RECIP_FRAC     = 16,
    parameter int OUT_WIDTH      = Q_WIDTH,
    parameter int MAX_NUM_WIDTH  = IN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_WIDTH-1:0] data_in [IN_PARALLELISM],
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out [IN_PARALLELISM],
    output logic [MAX_NUM_WIDTH-1:0]   data_out_max_num,
    output logic                       data_out_valid,
    input  logic                       data_out_ready
);

    localparam int QW    = recip_width(RECIP_FRAC);
    localparam int PW    = IN_WIDTH + QW + 1;
    localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    localparam logic [QW-1:0]        DIVIDEND = QW'(Q_MAX) << RECIP_FRAC;
    localparam logic signed [PW-1:0] RND_BIAS = PW'(round_bias(RECIP_FRAC));
    localparam logic signed [PW-1:0] SAT_HI   = PW'(Q_MAX);
    localparam logic signed [PW-1:0] SAT_LO   = -SAT_HI;

    // |x| in MAX_NUM_WIDTH unsigned; the most negative input maps to 2^(IN_WIDTH-1).
    function automatic logic [MAX_NUM_WIDTH-1:0] abs_val(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] ext;
        logic signed [IN_WIDTH:0] mag;
        ext = x;
        mag = ext[IN_WIDTH] ? -ext : ext;
        return MAX_NUM_WIDTH'($unsigned(mag));
    endfunction

    // Clamp to the symmetric code range so -128 can never appear.
    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
        if (v > SAT_HI)
            return OUT_WIDTH'(SAT_HI);
        else if (v < SAT_LO)
            return OUT_WIDTH'(SAT_LO);
        else
            return OUT_WIDTH'(v);
    endfunction

    // x * R rounded half toward +inf at the RECIP_FRAC binary point, then clamped.
    function automatic logic signed [OUT_WIDTH-1:0] quantize(input logic signed [IN_WIDTH-1:0] x,
                                                             input logic [QW-1:0] r);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] re;
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] q;
        xe = PW'(x);
        re = $signed(PW'(r));
        p  = xe * re;
        q  = (p + RND_BIAS) >>> RECIP_FRAC;
        return saturate(q);
    endfunction

    quant_state_t state, next_state;

    logic signed [IN_WIDTH-1:0] vec_buf [IN_DEPTH][IN_PARALLELISM];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           sel;
    logic [MAX_NUM_WIDTH-1:0]   tracker;
    logic [MAX_NUM_WIDTH-1:0]   absmax;
    logic [MAX_NUM_WIDTH-1:0]   beat_max;
    logic                       last_loaded;

    logic                       in_fire;
    logic                       out_fire;
    logic                       last_in;

    logic                       div_busy;
    logic                       div_done;
    logic [QW-1:0]              recip;

    logic signed [OUT_WIDTH-1:0] q_next [IN_PARALLELISM];

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;
    assign last_in  = in_fire && (wr_ptr == PTR_W'(IN_DEPTH - 1));

    // Running absmax including the beat currently on the input; on the last
    // beat this is the whole-vector absmax and feeds the divider directly.
    always_comb begin
        beat_max = tracker;
        for (int i = 0; i < IN_PARALLELISM; i++) begin
            if (abs_val(data_in[i]) > beat_max)
                beat_max = abs_val(data_in[i]);
        end
    end

    fixed_serial_divider #(
        .DIVIDEND_WIDTH (QW),
        .DIVISOR_WIDTH  (MAX_NUM_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (last_in),
        .dividend (DIVIDEND),
        .divisor  (beat_max),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (recip)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= FILL;
        else
            state <= next_state;
    end

    // FSM: next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            FILL:    if (last_in) next_state = DIV;
            DIV:     if (div_done && !div_busy) next_state = DRAIN;
            DRAIN:   if (out_fire && last_loaded) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    // FSM: outputs (single buffer, so input is closed outside FILL)
    always_comb begin
        data_in_ready = (state == FILL);
    end

    // Beat 0 is loaded as the divide completes; later beats follow rd_ptr.
    assign sel = (state == DRAIN) ? rd_ptr : '0;

    always_comb begin
        for (int i = 0; i < IN_PARALLELISM; i++)
            q_next[i] = quantize(vec_buf[sel][i], recip);
    end

    always_ff @(posedge clk) begin
        if (in_fire)
            vec_buf[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tracker          <= '0;
            absmax           <= '0;
            last_loaded      <= 1'b0;
            data_out_valid   <= 1'b0;
            data_out_max_num <= '0;
            for (int i = 0; i < IN_PARALLELISM; i++)
                data_out[i] <= '0;
        end else begin
            if (in_fire) begin
                wr_ptr  <= last_in ? '0 : wr_ptr + 1'b1;
                tracker <= last_in ? '0 : beat_max;
                if (last_in)
                    absmax <= beat_max;
            end

            if (state == DIV && div_done) begin
                data_out         <= q_next;
                data_out_max_num <= absmax;
                data_out_valid   <= 1'b1;
                rd_ptr           <= PTR_W'(1);
                last_loaded      <= (IN_DEPTH == 1);
            end else if (state == DRAIN && out_fire) begin
                if (last_loaded) begin
                    data_out_valid <= 1'b0;
                    last_loaded    <= 1'b0;
                    rd_ptr         <= '0;
                end else begin
                    data_out    <= q_next;
                    last_loaded <= (rd_ptr == PTR_W'(IN_DEPTH - 1));
                    rd_ptr      <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_absmax_quantizer.sv
// Scoreboard bench for fixed_absmax_quantizer (default parameters).
// Stimulus pushes expected beats into a queue; a negedge monitor pops and
// compares whenever an output handshake is about to occur.
module tb_fixed_absmax_quantizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [15:0] data_in [4];
    logic               data_in_valid;
    logic               data_in_ready;
    logic signed [7:0]  data_out [4];
    logic [15:0]        data_out_max_num;
    logic               data_out_valid;
    logic               data_out_ready;

    fixed_absmax_quantizer dut (
        .clk              (clk),
        .rst              (rst),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .data_out         (data_out),
        .data_out_max_num (data_out_max_num),
        .data_out_valid   (data_out_valid),
        .data_out_ready   (data_out_ready)
    );

    typedef struct {
        logic [31:0] codes;
        logic [15:0] mx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    logic signed [15:0] vec [8];

    localparam logic [63:0] RESET_VIEW = 64'h2_0000_0000_0000;

    function automatic logic [31:0] packed_out();
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = data_out[l];
        return r;
    endfunction

    function automatic logic [63:0] reset_view();
        return 64'({data_in_ready, data_out_valid, packed_out(), data_out_max_num});
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    // Reference: absmax over the vector, R = floor(127*2^16/absmax),
    // q = floor((x*R + 2^15) / 2^16) clamped to [-127,127].
    task automatic push_model();
        longint mx, r, p, q, a;
        exp_t e;
        mx = 0;
        for (int i = 0; i < 8; i++) begin
            a = (vec[i] < 0) ? -longint'(vec[i]) : longint'(vec[i]);
            if (a > mx) mx = a;
        end
        r = (mx == 0) ? 0 : (longint'(127) * 65536) / mx;
        for (int b = 0; b < 2; b++) begin
            e.mx = 16'(mx);
            for (int l = 0; l < 4; l++) begin
                p = longint'(vec[b*4+l]) * r;
                q = (p + 32768) >>> 16;
                if (q > 127) q = 127;
                if (q < -127) q = -127;
                e.codes[8*l +: 8] = q[7:0];
            end
            sb.push_back(e);
        end
    endtask

    task automatic rand_vec();
        int sh;
        sh = $urandom_range(0, 14);
        for (int i = 0; i < 8; i++) vec[i] = $signed(16'($urandom)) >>> sh;
        if ($urandom_range(0, 5) == 0) vec[$urandom_range(0, 7)] = -16'sd32768;
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input bit gaps);
        int n;
        push_model();
        for (int b = 0; b < 2; b++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            for (int l = 0; l < 4; l++) data_in[l] = vec[b*4+l];
            data_in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!data_in_ready && n < 300) begin @(negedge clk); n++; end
            if (n >= 300) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: data_in_ready stayed %b, expected 1", data_in_ready);
            end
            @(posedge clk); #1;
            data_in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || !data_in_ready || data_out_valid) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check(name, 64'({sb.size(), 30'd0, data_in_ready, data_out_valid}), 64'h2);
    endtask

    always @(negedge clk) begin
        if (rst && data_out_valid && data_out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra_beat: got codes %h max %0d, expected no output",
                         packed_out(), data_out_max_num);
            end else begin
                mon_e = sb.pop_front();
                if (packed_out() !== mon_e.codes || data_out_max_num !== mon_e.mx) begin
                    miscompares++;
                    $display("FAIL sb_beat: got codes %h max %0d, expected codes %h max %0d",
                             packed_out(), data_out_max_num, mon_e.codes, mon_e.mx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        logic [63:0] hold;
        bit done_b2b;

        rst            = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        for (int l = 0; l < 4; l++) data_in[l] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", reset_view(), RESET_VIEW);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic + rounding, with first-output latency.
        data_out_ready = 1'b1;
        vec = '{16'sd254, -16'sd127, 16'sd0, 16'sd1, 16'sd2, -16'sd254, 16'sd127, 16'sd63};
        send(1'b0);
        cycles = 0;
        while (!data_out_valid && cycles < 100) begin @(posedge clk); #1; cycles++; end
        check("first_valid_latency", 64'(cycles), 64'd24);
        drain("drain_basic");

        // Negative extreme.
        vec = '{-16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, 16'sd0, 16'sd0};
        send(1'b0);
        drain("drain_negext");

        // Zero vector.
        vec = '{default: 16'sd0};
        send(1'b0);
        drain("drain_zero");

        // Backpressure on beat 0.
        data_out_ready = 1'b0;
        rand_vec();
        send(1'b0);
        cycles = 0;
        while (!data_out_valid && cycles < 100) begin @(posedge clk); #1; cycles++; end
        check("bp_valid_seen", 64'(data_out_valid), 64'd1);
        hold = 64'({data_in_ready, data_out_valid, packed_out(), data_out_max_num});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold", 64'({data_in_ready, data_out_valid, packed_out(), data_out_max_num}), hold);
        end
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_mid", 64'(data_in_ready), 64'd0);
        @(posedge clk); #1;
        check("bp_in_ready_back", 64'(data_in_ready), 64'd1);
        drain("drain_bp");

        // Reset in the middle of the divide.
        vec = '{16'sd300, -16'sd5, 16'sd7, 16'sd9, 16'sd11, 16'sd13, -16'sd17, 16'sd19};
        send(1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("middiv_reset", reset_view(), RESET_VIEW);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        vec = '{default: 16'sd1};
        send(1'b0);
        drain("drain_after_reset");

        // Back-to-back random vectors with gaps and random output backpressure.
        done_b2b = 1'b0;
        fork
            begin
                for (int v = 0; v < 6; v++) begin
                    rand_vec();
                    send(1'b1);
                end
                done_b2b = 1'b1;
            end
            begin
                while (!done_b2b) begin
                    @(posedge clk); #1;
                    data_out_ready = 1'($urandom_range(0, 1));
                end
                data_out_ready = 1'b1;
            end
        join
        drain("drain_b2b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
